// File: rtl/ec_pkg.sv
// ec_pkg: state encoding and modular add/sub/mul helpers for the EC point unit.
package ec_pkg;
  localparam int NMAX = 256;
  typedef enum logic [3:0] {IDLE, CHECK, PREP, PREP2, INV, INV_WAIT, LAMBDA, X3, Y3, DONE} state_t;
  function automatic logic [NMAX-1:0] mod_add(input logic [NMAX-1:0] x, y, m);
    logic [NMAX:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (s >= {1'b0, m}) ? NMAX'(s - {1'b0, m}) : NMAX'(s);
  endfunction
  function automatic logic [NMAX-1:0] mod_sub(input logic [NMAX-1:0] x, y, m);
    return (x >= y) ? x - y : x + m - y;
  endfunction
  function automatic logic [NMAX-1:0] mod_mul(input logic [NMAX-1:0] x, y, m);
    logic [2*NMAX-1:0] t;
    t = {{NMAX{1'b0}}, x} * {{NMAX{1'b0}}, y};
    return NMAX'(t % {{NMAX{1'b0}}, m});
  endfunction
endpackage

// File: rtl/ec_point_unit_mod_inv.sv
// mod_inv: binary extended-Euclid inverse mod odd p, one reduction step per cycle.
module mod_inv
  import ec_pkg::*;
#(parameter int N = 256) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] p,
  input  logic [N-1:0] a,
  output logic         done,
  output logic [N-1:0] inv
);
  logic [N-1:0] r_u, r_v, r_x1, r_x2, r_inv;
  logic         r_run, r_done;
  function automatic logic [N-1:0] f_half(input logic [N-1:0] x, m);
    logic [N:0] s;
    s = x[0] ? {1'b0, x} + {1'b0, m} : {1'b0, x};
    return s[N:1];
  endfunction
  function automatic logic [N-1:0] f_sub(input logic [N-1:0] x, y, m);
    return N'(mod_sub(NMAX'(x), NMAX'(y), NMAX'(m)));
  endfunction
  // Odd/odd steps subtract and halve together, so every step drops a bit of u or v.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_run  <= 1'b0;
      r_done <= 1'b0;
      r_inv  <= '0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_u   <= a;
        r_v   <= p;
        r_x1  <= N'(1);
        r_x2  <= '0;
        r_run <= 1'b1;
      end else if (r_run) begin
        if (r_u == N'(1) || r_v == N'(1)) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
          r_inv  <= (r_u == N'(1)) ? r_x1 : r_x2;
        end else if (!r_u[0]) begin
          r_u  <= r_u >> 1;
          r_x1 <= f_half(r_x1, p);
        end else if (!r_v[0]) begin
          r_v  <= r_v >> 1;
          r_x2 <= f_half(r_x2, p);
        end else if (r_u >= r_v) begin
          r_u  <= (r_u - r_v) >> 1;
          r_x1 <= f_half(f_sub(r_x1, r_x2, p), p);
        end else begin
          r_v  <= (r_v - r_u) >> 1;
          r_x2 <= f_half(f_sub(r_x2, r_x1, p), p);
        end
      end
    end
  end
  assign done = r_done;
  assign inv  = r_inv;
endmodule

// File: rtl/ec_point_unit.sv
// ec_point_unit: GF(p) short-Weierstrass P+Q with automatic doubling and an explicit infinity flag.
module ec_point_unit
  import ec_pkg::*;
#(parameter int N = 256) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] p,
  input  logic [N-1:0] a,
  input  logic [N-1:0] x1,
  input  logic [N-1:0] y1,
  input  logic         inf1,
  input  logic [N-1:0] x2,
  input  logic [N-1:0] y2,
  input  logic         inf2,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] x3,
  output logic [N-1:0] y3,
  output logic         inf3
);
  state_t       r_state;
  logic [N-1:0] r_p, r_a, r_x1, r_y1, r_x2, r_y2, r_num, r_den, r_lam, r_rx3, r_x3, r_y3;
  logic         r_inf1, r_inf2, r_dbl, r_busy, r_done, r_inf3;
  logic [N-1:0] w_ma, w_mb, w_mul, w_inv;
  logic         w_inv_done, w_neg, w_special;
  function automatic logic [N-1:0] f_add(input logic [N-1:0] x, y, m);
    return N'(mod_add(NMAX'(x), NMAX'(y), NMAX'(m)));
  endfunction
  function automatic logic [N-1:0] f_sub(input logic [N-1:0] x, y, m);
    return N'(mod_sub(NMAX'(x), NMAX'(y), NMAX'(m)));
  endfunction
  // One shared multiplier; its operands are chosen by the current state.
  assign w_ma  = (r_state == PREP) ? r_x1 : (r_state == LAMBDA) ? r_num : r_lam;
  assign w_mb  = (r_state == PREP) ? r_x1 : (r_state == LAMBDA) ? w_inv :
                 (r_state == X3) ? r_lam : f_sub(r_x1, r_rx3, r_p);
  assign w_mul = N'(mod_mul(NMAX'(w_ma), NMAX'(w_mb), NMAX'(r_p)));
  assign w_neg = (r_x1 == r_x2) && (f_add(r_y1, r_y2, r_p) == '0);
  assign w_special = r_inf1 || r_inf2 || w_neg;
  mod_inv #(.N(N)) u_inv (
    .clk   (clk),
    .reset (reset),
    .start (r_state == INV),
    .p     (r_p),
    .a     (r_den),
    .done  (w_inv_done),
    .inv   (w_inv)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_x3    <= '0;
      r_y3    <= '0;
      r_inf3  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_p     <= p;
          r_a     <= a;
          r_x1    <= x1;
          r_y1    <= y1;
          r_inf1  <= inf1;
          r_x2    <= x2;
          r_y2    <= y2;
          r_inf2  <= inf2;
          r_busy  <= 1'b1;
          r_state <= CHECK;
        end
        CHECK: begin
          r_dbl   <= (r_x1 == r_x2) && (r_y1 == r_y2);
          r_state <= w_special ? DONE : PREP;
          if (w_special) begin
            r_done <= 1'b1;
            r_x3   <= r_inf1 ? (r_inf2 ? '0 : r_x2) : (r_inf2 ? r_x1 : '0);
            r_y3   <= r_inf1 ? (r_inf2 ? '0 : r_y2) : (r_inf2 ? r_y1 : '0);
            r_inf3 <= r_inf1 ? r_inf2 : !r_inf2;
          end
        end
        PREP: begin
          r_num   <= r_dbl ? w_mul : f_sub(r_y2, r_y1, r_p);
          r_den   <= r_dbl ? f_add(r_y1, r_y1, r_p) : f_sub(r_x2, r_x1, r_p);
          r_state <= r_dbl ? PREP2 : INV;
        end
        PREP2: begin
          r_num   <= f_add(f_add(f_add(r_num, r_num, r_p), r_num, r_p), r_a, r_p);
          r_state <= INV;
        end
        INV:      r_state <= INV_WAIT;
        INV_WAIT: if (w_inv_done) r_state <= LAMBDA;
        LAMBDA: begin
          r_lam   <= w_mul;
          r_state <= X3;
        end
        X3: begin
          r_rx3   <= f_sub(f_sub(w_mul, r_x1, r_p), r_x2, r_p);
          r_state <= Y3;
        end
        Y3: begin
          r_x3    <= r_rx3;
          r_y3    <= f_sub(w_mul, r_y1, r_p);
          r_inf3  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign busy = r_busy;
  assign done = r_done;
  assign x3   = r_x3;
  assign y3   = r_y3;
  assign inf3 = r_inf3;
endmodule

// File: tb/tb_ec_point_unit.sv
// tb_ec_point_unit: directed vectors on y^2 = x^3 + 2x + 2 over GF(17) with hand-computed results.
module tb_ec_point_unit;
  logic       clk = 1'b0;
  logic       reset, start, inf1, inf2, busy, done, inf3;
  logic [7:0] p, a, x1, y1, x2, y2, x3, y3;
  int         n_chk = 0, n_err = 0, lat, n_done;

  ec_point_unit #(.N(8)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .p     (p),
    .a     (a),
    .x1    (x1),
    .y1    (y1),
    .inf1  (inf1),
    .x2    (x2),
    .y2    (y2),
    .inf2  (inf2),
    .busy  (busy),
    .done  (done),
    .x3    (x3),
    .y3    (y3),
    .inf3  (inf3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic op(input int ax1, ay1, ai1, ax2, ay2, ai2, input bit glitch, output int l);
    @(negedge clk);
    x1 = 8'(ax1); y1 = 8'(ay1); inf1 = 1'(ai1);
    x2 = 8'(ax2); y2 = 8'(ay2); inf2 = 1'(ai2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x1 = 8'hAA; y1 = 8'hAA; x2 = 8'hAA; y2 = 8'hAA;
    inf1 = ~inf1; inf2 = ~inf2;
    l = 1;
    check("busy_after_start", int'(busy), 1);
    while (!done && l < 100) begin
      start = glitch && (l == 3 || l == 5);
      @(negedge clk);
      l++;
    end
    start = 1'b0;
    check("done_seen", int'(done), 1);
    @(negedge clk);
    check("busy_after_done", int'(busy), 0);
    check("done_one_cycle", int'(done), 0);
  endtask

  task automatic res(input string tag, input int l, el, ex, ey, ei);
    check({tag, "_latency"}, l, el);
    check({tag, "_x3"}, int'(x3), ex);
    check({tag, "_y3"}, int'(y3), ey);
    check({tag, "_inf3"}, int'(inf3), ei);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; p = 8'd17; a = 8'd2;
    x1 = '0; y1 = '0; x2 = '0; y2 = '0; inf1 = 1'b0; inf2 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    res("reset", 0, 0, 0, 0, 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    op(5, 1, 0, 5, 1, 0, 0, lat);   res("dbl", lat, 11, 6, 3, 0);
    op(5, 1, 0, 6, 3, 0, 0, lat);   res("add1", lat, 9, 10, 6, 0);
    op(10, 6, 0, 5, 1, 0, 0, lat);  res("add2", lat, 14, 3, 1, 0);
    op(5, 1, 0, 5, 16, 0, 0, lat);  res("inverse_pair", lat, 2, 0, 0, 1);
    op(7, 0, 0, 7, 0, 0, 0, lat);   res("dbl_y0", lat, 2, 0, 0, 1);
    op(0, 0, 1, 5, 1, 0, 0, lat);   res("inf1", lat, 2, 5, 1, 0);
    op(0, 0, 1, 0, 0, 1, 0, lat);   res("inf_both", lat, 2, 0, 0, 1);
    op(6, 3, 0, 9, 9, 1, 0, lat);   res("inf2", lat, 2, 6, 3, 0);
    op(5, 1, 0, 6, 3, 0, 1, lat);   res("handshake", lat, 9, 10, 6, 0);
    n_done = 0;
    repeat (12) begin
      @(negedge clk);
      n_done += int'(done);
    end
    check("no_extra_done", n_done, 0);
    @(negedge clk);
    x1 = 8'd5; y1 = 8'd1; inf1 = 1'b0; x2 = 8'd5; y2 = 8'd1; inf2 = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("midop_busy", int'(busy), 1);
    check("midop_hold_x3", int'(x3), 10);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    res("midop_reset", 0, 0, 0, 0, 0);
    check("midop_reset_busy", int'(busy), 0);
    check("midop_reset_done", int'(done), 0);
    op(5, 1, 0, 5, 1, 0, 0, lat);   res("dbl_after_reset", lat, 11, 6, 3, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/ec_point_unit.md
# ec_point_unit

Parametrised elliptic-curve point unit over GF(p) for short-Weierstrass curves y² = x³ + a·x + b. It computes P + Q and automatically selects doubling when P = Q. The point at infinity is carried as an explicit flag bit rather than a tri-state encoding, and a start/busy/done handshake sequences each operation. It is the arithmetic core driven by the scalar-multiplication controller and replaces the earlier add-only point adder.

## Interface
Parameters:
- N, 256, field/coordinate width in bits.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request; accepted only in IDLE.
- p  in  N  field prime, odd, > 3; sampled on start.
- a  in  N  curve coefficient a, reduced (< p); sampled on start.
- x1, y1  in  N  point P, reduced (< p); sampled on start.
- inf1  in  1  P is the point at infinity; x1/y1 are ignored when set.
- x2, y2  in  N  point Q, reduced (< p); sampled on start.
- inf2  in  1  Q is the point at infinity.
- busy  out  1  high from the cycle after an accepted start through the done cycle.
- done  out  1  one-cycle pulse; result is valid.
- x3, y3  out  N  result coordinates; both are 0 when inf3 = 1.
- inf3  out  1  result is the point at infinity.

## Operation
- All operands are latched on an accepted start; input changes while busy have no effect.
- CHECK state classifies the operation, in priority order:
  1. inf1 → result Q.
  2. inf2 → result P.
  3. x1 = x2 and (y1 + y2) mod p = 0 → infinity. This also covers doubling a point with y = 0.
  4. x1 = x2 and y1 = y2 → doubling.
  5. Otherwise → addition.
- Special cases 1–3 skip directly to DONE.
- Addition: num = y2 − y1, den = x2 − x1.
- Doubling: num = 3·x1² + a, den = 2·y1.
- Then, in order:
  - den⁻¹ from mod_inv.
  - λ = num·den⁻¹.
  - x3 = λ² − x1 − x2.
  - y3 = λ·(x1 − x3) − y1.
- All arithmetic is mod p. Every intermediate is held reduced in [0, p−1] in N-bit registers. Sums are formed at N+1 bits before conditional subtraction of p. Products are formed at 2N bits, then reduced.
- FSM states and transitions:
  - IDLE → CHECK on start.
  - CHECK → DONE for special cases.
  - CHECK → PREP otherwise. PREP computes num/den; doubling needs two sub-steps, PREP and PREP2.
  - PREP/PREP2 → INV (pulse inv_start) → INV_WAIT until inv_done.
  - INV_WAIT → LAMBDA → X3 → Y3 → DONE → IDLE.
- Outputs x3/y3/inf3 are updated only in DONE and hold until the next DONE.
- start while busy is ignored and not queued. start in the DONE cycle is also ignored.
- Reset mid-operation: FSM → IDLE, mod_inv reset, in-flight result discarded.

## Timing
- Reset values: busy = 0, done = 0, x3 = 0, y3 = 0, inf3 = 0, state = IDLE.
- Start accepted at cycle 0 → busy = 1 at cycle 1 (CHECK).
- Special case: done at cycle 2.
- Addition: done at cycle 7 + Linv.
- Doubling: done at cycle 8 + Linv.
- Linv is the number of cycles from inv_start to inv_done. It is data-dependent and bounded by 2N + 2.
- busy falls in the cycle after done. The next start is accepted from that cycle on.

## Structure
- Package ec_pkg holds:
  - the state enum (IDLE, CHECK, PREP, PREP2, INV, INV_WAIT, LAMBDA, X3, Y3, DONE);
  - functions mod_add, mod_sub and mod_mul, parameterised by N through the package parameter.
- One sub-module: mod_inv.
  - Binary extended-Euclid inverse, N-bit.
  - Ports: clk, reset, start, p, a, done, inv.
  - Its done is a one-cycle pulse; its input is never 0 in this unit.
- The top level holds the FSM, operand registers and the datapath, and shares a single mod_mul per state.

## Test plan
Curve for all scenarios: N = 8, p = 17, a = 2, G = (5,1).
- Doubling: start with P = Q = (5,1) → done with (6,3), inf3 = 0; latency = 8 + Linv.
- Addition: P = (5,1), Q = (6,3) → (10,6); then P = (10,6), Q = (5,1) → (3,1).
- Inverse pair: P = (5,1), Q = (5,16) → inf3 = 1, x3 = y3 = 0, done at cycle 2.
- Infinity operand: inf1 = 1, Q = (5,1) → (5,1) at cycle 2. inf1 = inf2 = 1 → inf3 = 1.
- Handshake: pulse start again at cycles 3 and 5 of an addition → ignored; a single done occurs with (10,6); busy is low the cycle after done.
- Reset mid-op: assert reset during INV_WAIT → next cycle busy = 0, done = 0, x3 = y3 = 0, inf3 = 0. A fresh start with P = Q = (5,1) then returns (6,3).
